// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage core: load-use and MDU stalls, taken-branch flushes, perf counters.
// Controls are combinational from inputs plus MDU state; a stall holds PC and IF/ID and bubbles ID/EX.
module pipe_hazard_ctrl #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_RegisterRt,
   input  logic [4:0]  IFID_RegisterRs,
   input  logic [4:0]  IFID_RegisterRt,
   input  logic        IFID_UsesRt,
   input  logic        IFID_ReadsHiLo,
   input  logic        IFID_MduOp,
   input  logic        IDEX_MduOp,
   input  logic        IDEX_MduIsDiv,
   input  logic        EX_BranchTaken,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFID_Flush,
   output logic        IDEX_Flush,
   output logic        MduBusy,
   output logic        MduDone,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu, mh;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // An MDU op arriving while BUSY cannot happen because ID stalls behind it; it is ignored.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      MduDone   = 1'b0;
      case (state)
         IDLE: begin
            if (IDEX_MduOp) begin
               state_nxt = BUSY;
               cnt_nxt   = IDEX_MduIsDiv ? DIV_CNT : MULT_CNT;
            end
         end
         BUSY: begin
            if (cnt > 4'd1) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               MduDone   = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end
         end
      endcase
   end

   assign MduBusy = (state == BUSY);

   always_comb begin
      lu = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
           ((IDEX_RegisterRt == IFID_RegisterRs) ||
            (IFID_UsesRt && (IDEX_RegisterRt == IFID_RegisterRt)));
      mh = (IFID_ReadsHiLo || IFID_MduOp) && (IDEX_MduOp || (state == BUSY));

      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      // A taken branch squashes the ID instruction, so its hazards are moot.
      if (EX_BranchTaken) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (lu || mh) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEX_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 16'd0;
         flush_count  <= 16'd0;
      end else begin
         if (!PCWrite && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
         if (EX_BranchTaken && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ALU forwarding unit and handles the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, and stalls on the multi-cycle multiply/divide unit (MDU). It drives PC/IF-ID write enables and the stage flush/bubble controls. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- MULT_LAT, 4, MDU busy cycles for mult/multu (1..15)
- DIV_LAT, 10, MDU busy cycles for div/divu (1..15)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_RegisterRt  in  5  load destination register
- IFID_RegisterRs  in  5  ID-stage source rs
- IFID_RegisterRt  in  5  ID-stage source rt
- IFID_UsesRt  in  1  ID instruction reads rt (R-type, store, beq/bne)
- IFID_ReadsHiLo  in  1  ID instruction is mfhi/mflo
- IFID_MduOp  in  1  ID instruction is mult/div
- IDEX_MduOp  in  1  EX instruction is mult/div (issue to MDU)
- IDEX_MduIsDiv  in  1  EX MDU op is a divide
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register write enable
- IFID_Flush  out  1  zero IF/ID instruction
- IDEX_Flush  out  1  zero ID/EX control (bubble)
- MduBusy  out  1  MDU FSM in BUSY
- MduDone  out  1  last BUSY cycle; HI/LO written at following edge
- stall_cycles  out  16  saturating count of cycles with PCWrite=0
- flush_count  out  16  saturating count of taken-branch flushes

## Operation
- Load-use hazard (lu): IDEX_MemRead && IDEX_RegisterRt!=0 && (IDEX_RegisterRt==IFID_RegisterRs || (IFID_UsesRt && IDEX_RegisterRt==IFID_RegisterRt)).
- MDU hazard (mh): (IFID_ReadsHiLo || IFID_MduOp) && (IDEX_MduOp || state==BUSY).
- Output priority:
  1. EX_BranchTaken: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IFIDWrite=1. lu/mh are ignored because the ID instruction is squashed.
  2. lu or mh: PCWrite=0, IFIDWrite=0, IDEX_Flush=1, IFID_Flush=0.
  3. Otherwise: PCWrite=1, IFIDWrite=1, both flushes 0.
- MDU FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE & IDEX_MduOp: go to BUSY; cnt <= IDEX_MduIsDiv ? DIV_LAT : MULT_LAT.
  - BUSY & cnt>1: cnt <= cnt-1.
  - BUSY & cnt==1: MduDone=1; go to IDLE; cnt <= 0.
  - IDEX_MduOp while BUSY is a protocol violation (ID stalls prevent it). It is ignored, and the bench asserts it never occurs.
- Counters:
  - stall_cycles increments on each cycle with PCWrite=0 and holds at 16'hFFFF.
  - flush_count increments on each cycle with EX_BranchTaken=1 and holds at 16'hFFFF.
- Register $0 never causes a load-use stall. MDU hazards do not depend on register numbers.

## Timing
- Reset values: state=IDLE, cnt=0, stall_cycles=0, flush_count=0. Consequently MduBusy=0 and MduDone=0. With all inputs 0, PCWrite=1, IFIDWrite=1, IFID_Flush=0, IDEX_Flush=0.
- Reset asserted mid-BUSY: FSM returns to IDLE at that edge, with no MduDone pulse. Counters clear at the same edge.
- PCWrite, IFIDWrite, IFID_Flush, IDEX_Flush, MduBusy and MduDone are combinational from current inputs plus registered state. There is no added latency.
- Load-use: exactly 1 stall cycle per occurrence. The following cycle the load is in MEM and forwarding covers the dependency.
- MDU op in EX at cycle N (FSM IDLE):
  - BUSY during cycles N+1 .. N+L, where L is the selected latency.
  - MduDone is high in cycle N+L.
  - A dependent mfhi/mflo held in ID stalls cycles N .. N+L (L+1 cycles) and enters EX at N+L+1.
- Same-cycle lu and EX_BranchTaken: the flush wins; no stall is counted.
- Same-cycle lu and mh: a single stall; stall_cycles increments by 1.

## Test plan
- Reset: assert reset 2 cycles with random inputs. All counters read 0, MduBusy=0, and PCWrite=1 once inputs are zeroed.
- Load-use: `lw $5` in EX (IDEX_MemRead=1, IDEX_RegisterRt=5), ID has rs=5. Result: one cycle of PCWrite=0/IFIDWrite=0/IDEX_Flush=1, and stall_cycles=1. Repeating with IDEX_RegisterRt=0 gives no stall. Repeating with rt match but IFID_UsesRt=0 gives no stall.
- Mult then mflo (MULT_LAT=4): PCWrite=0 for exactly 5 cycles, MduBusy high 4 cycles, MduDone a single pulse in the 4th busy cycle, and stall_cycles=5. Repeating with div (DIV_LAT=10) gives 11 stall cycles.
- Branch priority: EX_BranchTaken=1 together with a load-use match. Result: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, flush_count+1, stall_cycles unchanged.
- Reset mid-divide: assert reset at busy cycle 3 of 10. FSM returns to IDLE, MduDone never pulses, and a subsequent mult behaves normally.
- Saturation: force 70000 load-use stall cycles. stall_cycles holds at 65535 with no wrap.
